// File: rtl/iob_cache_line_fill_pkg.sv
// Shared types and default geometry for the cache line-fill miss handler.
package iob_cache_line_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } fill_state_e;

  localparam int unsigned DEF_N_WAYS        = 8;
  localparam int unsigned DEF_NLINES_W      = 7;
  localparam int unsigned DEF_TAG_W         = 20;
  localparam int unsigned DEF_WORD_OFFSET_W = 2;
  localparam int unsigned DEF_DATA_W        = 32;

endpackage

// File: rtl/iob_cache_line_fill_victim_select.sv
// Victim choice: first invalid way (lowest index) wins, otherwise the policy's pick.
module iob_cache_line_fill_victim_select
  import iob_cache_line_fill_pkg::*;
#(
  parameter int unsigned N_WAYS  = DEF_N_WAYS,
  parameter int unsigned NWAYS_W = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0]  valid_bits_i,
  input  logic [NWAYS_W-1:0] policy_bin_i,
  output logic [NWAYS_W-1:0] victim_bin_o
);

  logic found;

  always_comb begin
    victim_bin_o = policy_bin_i;
    found        = 1'b0;
    for (int i = 0; i < int'(N_WAYS); i++) begin
      if (!valid_bits_i[i] && !found) begin
        victim_bin_o = NWAYS_W'(i);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_cache_line_fill.sv
// Read-miss line fill: pick victim, burst line from backend into data memory,
// then write tag/valid and update the replacement policy in a single commit cycle.
module iob_cache_line_fill
  import iob_cache_line_fill_pkg::*;
#(
  parameter int unsigned N_WAYS        = DEF_N_WAYS,
  parameter int unsigned NWAYS_W       = $clog2(N_WAYS),
  parameter int unsigned NLINES_W      = DEF_NLINES_W,
  parameter int unsigned TAG_W         = DEF_TAG_W,
  parameter int unsigned WORD_OFFSET_W = DEF_WORD_OFFSET_W,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned BE_ADDR_W     = TAG_W + NLINES_W + WORD_OFFSET_W
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     cke_i,
  input  logic                     miss_valid_i,
  output logic                     miss_ready_o,
  input  logic [TAG_W-1:0]         miss_tag_i,
  input  logic [NLINES_W-1:0]      miss_line_i,
  input  logic [N_WAYS-1:0]        valid_bits_i,
  input  logic [NWAYS_W-1:0]       way_select_bin_i,
  output logic                     be_req_valid_o,
  input  logic                     be_req_ready_i,
  output logic [BE_ADDR_W-1:0]     be_addr_o,
  input  logic                     be_rvalid_i,
  input  logic [DATA_W-1:0]        be_rdata_i,
  output logic                     dmem_we_o,
  output logic [NWAYS_W-1:0]       dmem_way_o,
  output logic [NLINES_W-1:0]      dmem_line_o,
  output logic [WORD_OFFSET_W-1:0] dmem_word_o,
  output logic [DATA_W-1:0]        dmem_data_o,
  output logic [N_WAYS-1:0]        tag_we_o,
  output logic [NLINES_W-1:0]      tag_line_o,
  output logic [TAG_W-1:0]         tag_o,
  output logic                     repl_we_o,
  output logic [N_WAYS-1:0]        repl_way_hit_o,
  output logic                     done_o
);

  localparam logic [WORD_OFFSET_W-1:0] LAST_WORD = '1;

  fill_state_e               state, state_nxt;
  logic [WORD_OFFSET_W-1:0]  cnt;
  logic [TAG_W-1:0]          tag_q;
  logic [NLINES_W-1:0]       line_q;
  logic [NWAYS_W-1:0]        victim_q, victim_nxt;
  logic                      accept, req_fire, word_wr, commit;
  logic [N_WAYS-1:0]         victim_oh;

  iob_cache_line_fill_victim_select #(
    .N_WAYS  (N_WAYS),
    .NWAYS_W (NWAYS_W)
  ) u_victim (
    .valid_bits_i (valid_bits_i),
    .policy_bin_i (way_select_bin_i),
    .victim_bin_o (victim_nxt)
  );

  assign victim_oh = N_WAYS'(1) << victim_q;

  // Handshakes and strobes are qualified by cke_i so a frozen cycle can neither
  // complete a handshake nor repeat a write once the clock enable returns.
  always_comb begin
    miss_ready_o   = (state == ST_IDLE) && cke_i;
    be_req_valid_o = (state == ST_REQ) && cke_i;
    accept         = miss_valid_i && miss_ready_o;
    req_fire       = be_req_valid_o && be_req_ready_i;
    word_wr        = (state == ST_FILL) && be_rvalid_i && cke_i;
    commit         = (state == ST_COMMIT) && cke_i;
    state_nxt      = state;
    unique case (state)
      ST_IDLE:   if (accept)                     state_nxt = ST_REQ;
      ST_REQ:    if (req_fire)                   state_nxt = ST_FILL;
      ST_FILL:   if (word_wr && cnt == LAST_WORD) state_nxt = ST_COMMIT;
      ST_COMMIT: if (commit)                     state_nxt = ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      tag_q    <= '0;
      line_q   <= '0;
      victim_q <= '0;
    end else if (cke_i) begin
      state <= state_nxt;
      if (accept) begin
        tag_q    <= miss_tag_i;
        line_q   <= miss_line_i;
        victim_q <= victim_nxt;
      end
      if (req_fire)     cnt <= '0;
      else if (word_wr) cnt <= cnt + 1'b1;
    end
  end

  assign be_addr_o      = {tag_q, line_q, {WORD_OFFSET_W{1'b0}}};
  assign dmem_we_o      = word_wr;
  assign dmem_way_o     = victim_q;
  assign dmem_line_o    = line_q;
  assign dmem_word_o    = cnt;
  assign dmem_data_o    = be_rdata_i;
  assign tag_we_o       = commit ? victim_oh : '0;
  assign tag_line_o     = line_q;
  assign tag_o          = tag_q;
  assign repl_we_o      = commit;
  assign repl_way_hit_o = commit ? victim_oh : '0;
  assign done_o         = commit;

endmodule

// File: tb/tb_iob_cache_line_fill.sv
// Randomized bench for iob_cache_line_fill against a transaction-level reference.
module tb_iob_cache_line_fill;
  localparam int N_WAYS = 8, NWAYS_W = 3, NLINES_W = 7, TAG_W = 20;
  localparam int WOW = 2, DATA_W = 32, BE_ADDR_W = TAG_W + NLINES_W + WOW;
  localparam int WORDS = 1 << WOW;

  logic clk = 0, arst = 1, cke = 1;
  logic miss_valid = 0, miss_ready;
  logic [TAG_W-1:0] miss_tag = '0;
  logic [NLINES_W-1:0] miss_line = '0;
  logic [N_WAYS-1:0] valid_bits = '0;
  logic [NWAYS_W-1:0] way_sel = '0;
  logic be_req_valid, be_req_ready = 0;
  logic [BE_ADDR_W-1:0] be_addr;
  logic be_rvalid = 0;
  logic [DATA_W-1:0] be_rdata = '0;
  logic dmem_we;
  logic [NWAYS_W-1:0] dmem_way;
  logic [NLINES_W-1:0] dmem_line;
  logic [WOW-1:0] dmem_word;
  logic [DATA_W-1:0] dmem_data;
  logic [N_WAYS-1:0] tag_we, repl_way_hit;
  logic [NLINES_W-1:0] tag_line;
  logic [TAG_W-1:0] tag;
  logic repl_we, done;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  iob_cache_line_fill dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready),
    .miss_tag_i(miss_tag), .miss_line_i(miss_line),
    .valid_bits_i(valid_bits), .way_select_bin_i(way_sel),
    .be_req_valid_o(be_req_valid), .be_req_ready_i(be_req_ready), .be_addr_o(be_addr),
    .be_rvalid_i(be_rvalid), .be_rdata_i(be_rdata),
    .dmem_we_o(dmem_we), .dmem_way_o(dmem_way), .dmem_line_o(dmem_line),
    .dmem_word_o(dmem_word), .dmem_data_o(dmem_data),
    .tag_we_o(tag_we), .tag_line_o(tag_line), .tag_o(tag),
    .repl_we_o(repl_we), .repl_way_hit_o(repl_way_hit), .done_o(done)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int ref_victim(input logic [N_WAYS-1:0] vb, input int pol);
    for (int i = 0; i < N_WAYS; i++) if (!vb[i]) return i;
    return pol;
  endfunction

  // One miss: accept, request (optionally stalled), fill (gaps/cke freezes), commit.
  // pat_len>0 forces the rvalid sequence; abort_at>=0 resets after that many words.
  task automatic run_miss(input logic [TAG_W-1:0] t, input logic [NLINES_W-1:0] ln,
                          input logic [N_WAYS-1:0] vb, input int pol, input int stall,
                          input int gap_pct, input int cke_pct, input logic [15:0] pat,
                          input int pat_len, input bit chk_lat, input int abort_at);
    int victim = ref_victim(vb, pol);
    logic [N_WAYS-1:0] oh = N_WAYS'(1) << victim;
    logic [63:0] addr = (64'(t) << (NLINES_W + WOW)) | (64'(ln) << WOW);
    int words = 0, lat = 0, guard = 0, pidx = 0;
    bit rv, ck;
    @(negedge clk);
    miss_valid = 1; miss_tag = t; miss_line = ln; valid_bits = vb; way_sel = NWAYS_W'(pol);
    cke = 1; be_rvalid = 0; be_req_ready = 0;
    #1 chk("idle_ready", miss_ready, 1);
    @(posedge clk);
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      miss_valid = $urandom % 2; valid_bits = $urandom; way_sel = $urandom;
      be_req_ready = (s == stall); be_rvalid = $urandom % 2;
      lat++;
      #1 chk("req_valid", be_req_valid, 1);
      chk("req_addr", be_addr, addr);
      chk("req_no_dmem", dmem_we, 0);
      chk("req_not_ready", miss_ready, 0);
      chk("req_no_tag", tag_we, 0);
      @(posedge clk);
    end
    miss_valid = 0;
    while (words < WORDS && guard < 200) begin
      @(negedge clk);
      if (pat_len > 0) rv = (pidx < pat_len) ? pat[pidx] : 1'b1;
      else rv = ($urandom % 100) >= gap_pct;
      ck = ($urandom % 100) >= cke_pct;
      pidx++;
      be_rvalid = rv; cke = ck; be_rdata = $urandom; be_req_ready = $urandom % 2;
      lat++;
      #1 chk("fill_we", dmem_we, rv && ck);
      if (rv && ck) begin
        chk("fill_word", dmem_word, words);
        chk("fill_way", dmem_way, victim);
        chk("fill_line", dmem_line, ln);
        chk("fill_data", dmem_data, be_rdata);
      end
      chk("fill_no_tag", tag_we, 0);
      chk("fill_no_done", done, 0);
      chk("fill_no_req", be_req_valid, 0);
      @(posedge clk);
      if (rv && ck) words++;
      guard++;
      if (abort_at >= 0 && words == abort_at) break;
    end
    if (guard >= 200) chk("fill_timeout", 0, 1);
    if (abort_at >= 0) begin
      @(negedge clk);
      cke = 1; be_rvalid = 1; arst = 1;
      #1 chk("abort_ready", miss_ready, 1);
      chk("abort_no_tag", tag_we, 0);
      chk("abort_no_done", done, 0);
      #2 arst = 0;
      @(negedge clk);
      be_rvalid = 0;
      #1 chk("abort_ready_next", miss_ready, 1);
      chk("abort_no_dmem", dmem_we, 0);
      chk("abort_no_tag2", tag_we, 0);
      return;
    end
    @(negedge clk);
    cke = 1; be_rvalid = $urandom % 2;
    lat++;
    #1 chk("commit_done", done, 1);
    chk("commit_tag_we", tag_we, oh);
    chk("commit_way_hit", repl_way_hit, oh);
    chk("commit_repl_we", repl_we, 1);
    chk("commit_line", tag_line, ln);
    chk("commit_tag", tag, t);
    chk("commit_no_dmem", dmem_we, 0);
    if (chk_lat) chk("latency", lat, 2 + WORDS);
    @(posedge clk);
  endtask

  initial begin
    #1;
    chk("rst_ready", miss_ready, 1);
    chk("rst_req", be_req_valid, 0);
    chk("rst_addr", be_addr, 0);
    chk("rst_dmem", dmem_we, 0);
    chk("rst_word", dmem_word, 0);
    chk("rst_tag_we", tag_we, 0);
    chk("rst_repl", {repl_we, repl_way_hit}, 0);
    chk("rst_done", done, 0);
    @(negedge clk); arst = 0;

    run_miss(20'hABCDE, 7'd3, 8'b1111_0111, 5, 0, 0, 0, '0, 0, 1, -1);
    run_miss(20'h12345, 7'd3, 8'hFF, 6, 0, 0, 0, '0, 0, 1, -1);
    run_miss(20'h0F0F0, 7'd77, 8'hFF, 2, 5, 0, 0, '0, 0, 0, -1);
    run_miss(20'h55555, 7'd9, 8'b0000_0001, 0, 0, 0, 0, 16'b1011001, 7, 0, -1);
    // cke freeze: forced low on most fill cycles, back-to-back misses follow
    run_miss(20'h00001, 7'd1, 8'hFF, 7, 0, 0, 60, '0, 0, 0, -1);
    run_miss(20'hFFFFF, 7'd127, 8'h7F, 1, 0, 0, 0, '0, 0, 1, -1);
    run_miss(20'h3C3C3, 7'd40, 8'hFF, 4, 1, 0, 0, '0, 0, 0, 2);
    run_miss(20'h3C3C3, 7'd40, 8'hFF, 4, 0, 0, 0, '0, 0, 1, -1);
    for (int n = 0; n < 25; n++) begin
      logic [N_WAYS-1:0] vb;
      vb = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
      run_miss(20'($urandom), 7'($urandom), vb, int'($urandom % N_WAYS),
               int'($urandom % 4), int'($urandom % 50), int'($urandom % 30),
               '0, 0, 0, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
